// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root block.
//   state_t    : controller states (IDLE, CALC, ROUND, HOLD)
//   RND_TRUNC  : rnd_mode value selecting truncation
//   RND_RNE    : rnd_mode value selecting round-to-nearest-even
//   rem_w()    : remainder width for a given mantissa width (MANT_W+3)
//   rad_w()    : radicand width for a given mantissa width (2*MANT_W+2)
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  function automatic int rem_w(input int mant_w);
    return mant_w + 3;
  endfunction

  function automatic int rad_w(input int mant_w);
    return 2 * mant_w + 2;
  endfunction

endpackage

// File: rtl/sqrt_iter_pipe_if.sv
// Handshake and data bundle around the square-root block.
//   in_valid/in_ready   : operand handshake (producer -> block)
//   rnd_mode            : 0 truncate, 1 round-nearest-even
//   sign_in, is_*_in,   : operand classification from the special-value
//   is_num, mant_in,      classifier, mantissa with implicit 1, signed
//   exp_in                unbiased exponent
//   out_valid/out_ready : result handshake (block -> packer)
//   sign_out, exp_out,  : result fields in the same format as the input
//   mant_out
//   special_out, invalid, inexact : result flags
//   iter_valid, iter_root         : per-iteration trace
// Modport slave is the block; modport master is the surrounding logic.
interface sqrt_iter_pipe_if #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 7
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     rnd_mode;
  logic                     sign_in;
  logic                     is_nan_in;
  logic                     is_pinf_in;
  logic                     is_ninf_in;
  logic                     is_num;
  logic        [MANT_W-1:0] mant_in;
  logic signed [EXP_W-1:0]  exp_in;
  logic                     out_valid;
  logic                     out_ready;
  logic                     sign_out;
  logic signed [EXP_W-1:0]  exp_out;
  logic        [MANT_W-1:0] mant_out;
  logic                     special_out;
  logic                     invalid;
  logic                     inexact;
  logic                     iter_valid;
  logic        [MANT_W:0]   iter_root;

  modport slave (
    input  in_valid, rnd_mode, sign_in, is_nan_in, is_pinf_in, is_ninf_in,
           is_num, mant_in, exp_in, out_ready,
    output in_ready, out_valid, sign_out, exp_out, mant_out, special_out,
           invalid, inexact, iter_valid, iter_root
  );

  modport master (
    output in_valid, rnd_mode, sign_in, is_nan_in, is_pinf_in, is_ninf_in,
           is_num, mant_in, exp_in, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, mant_out, special_out,
           invalid, inexact, iter_valid, iter_root
  );

endinterface

// File: rtl/sqrt_step.sv
// One digit-by-digit square-root step (combinational).
//   rem_in   : current partial remainder
//   root_in  : current partial root
//   rad_top  : next two radicand bits (MSB first)
//   rem_out  : remainder after the trial subtraction
//   root_bit : root bit produced by this step
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter  int MANT_W = 11,
  localparam int REM_W  = rem_w(MANT_W)
) (
  input  logic [REM_W-1:0] rem_in,
  input  logic [MANT_W:0]  root_in,
  input  logic [1:0]       rad_top,
  output logic [REM_W-1:0] rem_out,
  output logic             root_bit
);

  // The shifted remainder keeps two extra bits so the compare sees every bit;
  // the bounded remainder guarantees the result fits back into REM_W.
  logic [REM_W+1:0] rem_sh;
  logic [REM_W+1:0] trial;

  assign rem_sh   = {rem_in, rad_top};
  assign trial    = (REM_W+2)'({root_in, 2'b01});
  assign root_bit = (rem_sh >= trial);
  assign rem_out  = root_bit ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);

endmodule

// File: rtl/sqrt_iter_pipe.sv
// Iterative square root of a normalised mantissa/exponent operand.
// One root bit per cycle (MANT_W result bits plus a guard bit), then a
// truncate or round-nearest-even step. Special operands bypass the
// iteration and are presented one cycle after accept.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sqrt_iter_pipe_if.slave (operand/result handshakes, trace)
module sqrt_iter_pipe
  import sqrt_pkg::*;
#(
  parameter int MANT_W   = 11,
  parameter int EXP_W    = 7,
  parameter int ZERO_EXP = -15,
  parameter int TRACE_EN = 1
) (
  input logic            clk,
  input logic            rst,
  sqrt_iter_pipe_if.slave bus
);

  localparam int REM_W = rem_w(MANT_W);
  localparam int RAD_W = rad_w(MANT_W);
  localparam int CNT_W = $clog2(MANT_W + 2);

  state_t                   state_q, state_d;
  logic        [REM_W-1:0]  rem_q, rem_nxt;
  logic        [MANT_W:0]   root_q, root_nxt;
  logic                     root_bit;
  logic        [RAD_W-1:0]  rad_q;
  logic        [CNT_W-1:0]  cnt_q;
  logic                     rnd_q;
  logic                     sign_q;
  logic signed [EXP_W-1:0]  exp_q;
  logic        [MANT_W-1:0] mant_q;
  logic                     special_q;
  logic                     invalid_q;
  logic                     inexact_q;
  logic                     iter_vld_q;
  logic        [MANT_W:0]   iter_root_q;
  logic                     in_special;
  logic                     in_passthru;
  logic        [MANT_W:0]   mant_adj;

  // Drop the guard bit and optionally round; a carry out of q is excluded
  // because the root never reaches 2^MANT_W - 0.5.
  function automatic logic [MANT_W-1:0] round_mant(input logic [MANT_W:0] root,
                                                   input logic sticky,
                                                   input logic rne);
    logic [MANT_W-1:0] q;
    logic              inc;
    q   = root[MANT_W:1];
    inc = rne & root[0] & (sticky | q[0]);
    return q + MANT_W'(inc);
  endfunction

  sqrt_step #(.MANT_W(MANT_W)) u_step (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .rad_top  (rad_q[RAD_W-1 -: 2]),
    .rem_out  (rem_nxt),
    .root_bit (root_bit)
  );

  assign root_nxt    = {root_q[MANT_W-1:0], root_bit};
  assign in_passthru = bus.is_nan_in | bus.is_pinf_in | bus.is_ninf_in;
  assign in_special  = in_passthru | ~bus.is_num | bus.sign_in;
  // Odd exponents fold one factor of two into the mantissa so the exponent
  // halves exactly; the floor shift then matches (exp-1)>>>1.
  assign mant_adj    = bus.exp_in[0] ? {bus.mant_in, 1'b0} : {1'b0, bus.mant_in};

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = ~rst;
        if (bus.in_valid && !rst) state_d = in_special ? HOLD : CALC;
      end
      CALC:  if (cnt_q == CNT_W'(1)) state_d = ROUND;
      ROUND: state_d = HOLD;
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rnd_q       <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      special_q   <= 1'b0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
      iter_vld_q  <= 1'b0;
      iter_root_q <= '0;
    end else begin
      state_q    <= state_d;
      iter_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            rnd_q     <= bus.rnd_mode;
            inexact_q <= 1'b0;
            invalid_q <= 1'b0;
            special_q <= in_special;
            if (in_passthru) begin
              sign_q <= bus.sign_in;
              exp_q  <= bus.exp_in;
              mant_q <= bus.mant_in;
            end else if (!bus.is_num) begin
              sign_q <= bus.sign_in;
              exp_q  <= EXP_W'(ZERO_EXP);
              mant_q <= '0;
            end else if (bus.sign_in) begin
              invalid_q <= 1'b1;
              sign_q    <= 1'b0;
              exp_q     <= '0;
              mant_q    <= '0;
            end else begin
              sign_q <= 1'b0;
              exp_q  <= bus.exp_in >>> 1;
              cnt_q  <= CNT_W'(MANT_W + 1);
            end
          end
        end
        CALC: begin
          cnt_q       <= cnt_q - CNT_W'(1);
          iter_vld_q  <= (TRACE_EN != 0);
          iter_root_q <= (TRACE_EN != 0) ? root_nxt : '0;
        end
        ROUND: begin
          mant_q    <= round_mant(root_q, |rem_q, rnd_q);
          inexact_q <= root_q[0] | (|rem_q);
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath; reloaded every idle cycle so accept captures it
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      rem_q  <= '0;
      root_q <= '0;
      rad_q  <= {mant_adj, {(MANT_W+1){1'b0}}};
    end else if (state_q == CALC) begin
      rem_q  <= rem_nxt;
      root_q <= root_nxt;
      rad_q  <= rad_q << 2;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    (state_q == ROUND) |-> !((&root_q[MANT_W:1]) && root_q[0] && rnd_q));

  assign bus.sign_out    = sign_q;
  assign bus.exp_out     = exp_q;
  assign bus.mant_out    = mant_q;
  assign bus.special_out = special_q;
  assign bus.invalid     = invalid_q;
  assign bus.inexact     = inexact_q;
  assign bus.iter_valid  = iter_vld_q;
  assign bus.iter_root   = iter_root_q;

endmodule

// File: tb/tb_sqrt_iter_pipe.sv
// Scoreboard bench for sqrt_iter_pipe (MANT_W = 11, EXP_W = 7).
module tb_sqrt_iter_pipe;

  localparam int MANT_W = 11;
  localparam int EXP_W  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt_iter_pipe_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

  sqrt_iter_pipe #(
    .MANT_W(MANT_W), .EXP_W(EXP_W), .ZERO_EXP(-15), .TRACE_EN(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int tag;
    bit sign;
    int ex;
    int mant;
    bit special;
    bit invalid;
    bit inexact;
    int lat;
    int iters;
    int root;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int tag, input bit s, input int ex, input int m,
                              input bit sp, input bit inv, input bit inx,
                              input int lat, input int iters, input int root);
    exp_t e;
    e.tag = tag; e.sign = s; e.ex = ex; e.mant = m; e.special = sp;
    e.invalid = inv; e.inexact = inx; e.lat = lat; e.iters = iters;
    e.root = root; e.acc = 0;
    return e;
  endfunction

  task automatic drive(input bit rnd, input bit sgn, input bit nan, input bit pinf,
                       input bit ninf, input bit num, input int mant, input int ex);
    bus.rnd_mode   = rnd;
    bus.sign_in    = sgn;
    bus.is_nan_in  = nan;
    bus.is_pinf_in = pinf;
    bus.is_ninf_in = ninf;
    bus.is_num     = num;
    bus.mant_in    = mant[MANT_W-1:0];
    bus.exp_in     = ex[EXP_W-1:0];
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic send(input int tag, input bit rnd, input bit sgn, input bit nan,
                      input bit pinf, input bit ninf, input bit num, input int mant,
                      input int ex, input exp_t e);
    int i;
    i = 0;
    while (!bus.in_ready && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    if (!bus.in_ready) begin
      check($sformatf("op%0d_accept_timeout", tag), 0, 1);
      return;
    end
    drive(rnd, sgn, nan, pinf, ninf, num, mant, ex);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() > 0 && i < 300) begin
      @(posedge clk); #1;
      i++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: latency at out_valid rise, stability while held, fields at handshake
  exp_t mon_e;
  bit   prev_ov = 1'b0;
  int   iter_cnt = 0;
  int   last_root = 0;
  int   snap_mant, snap_exp, snap_sign, snap_flags;

  always @(negedge clk) begin
    if (rst) begin
      iter_cnt  = 0;
      last_root = 0;
      prev_ov   = 1'b0;
    end else begin
      if (bus.iter_valid) begin
        iter_cnt++;
        last_root = int'(bus.iter_root);
      end
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check($sformatf("op%0d_latency", sb[0].tag), cyc - sb[0].acc + 1, sb[0].lat);
        end
        snap_mant  = int'(bus.mant_out);
        snap_exp   = int'(bus.exp_out);
        snap_sign  = int'(bus.sign_out);
        snap_flags = int'({bus.special_out, bus.invalid, bus.inexact});
      end else if (bus.out_valid) begin
        check("hold_stable_mant", int'(bus.mant_out), snap_mant);
        check("hold_stable_exp", int'(bus.exp_out), snap_exp);
        check("hold_stable_sign", int'(bus.sign_out), snap_sign);
        check("hold_stable_flags", int'({bus.special_out, bus.invalid, bus.inexact}), snap_flags);
      end
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        check($sformatf("op%0d_sign", mon_e.tag), int'(bus.sign_out), int'(mon_e.sign));
        check($sformatf("op%0d_exp", mon_e.tag), int'(bus.exp_out), mon_e.ex);
        check($sformatf("op%0d_mant", mon_e.tag), int'(bus.mant_out), mon_e.mant);
        check($sformatf("op%0d_special", mon_e.tag), int'(bus.special_out), int'(mon_e.special));
        check($sformatf("op%0d_invalid", mon_e.tag), int'(bus.invalid), int'(mon_e.invalid));
        check($sformatf("op%0d_inexact", mon_e.tag), int'(bus.inexact), int'(mon_e.inexact));
        check($sformatf("op%0d_iters", mon_e.tag), iter_cnt, mon_e.iters);
        if (mon_e.iters > 0)
          check($sformatf("op%0d_root", mon_e.tag), last_root, mon_e.root);
        iter_cnt = 0;
      end
      prev_ov = bus.out_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_mant_out", int'(bus.mant_out), 0);
    check("rst_special", int'(bus.special_out), 0);
    check("rst_iter_valid", int'(bus.iter_valid), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", int'(bus.in_ready), 1);

    // tag, rnd, sign, nan, pinf, ninf, num, mant, exp
    send(1, 1, 0, 0, 0, 0, 1, 'h400, 2, mk(1, 0, 1, 'h400, 0, 0, 0, 14, 12, 'h800));   // 4.0
    drain();
    send(2, 1, 0, 0, 0, 0, 1, 'h400, 1, mk(2, 0, 0, 'h5A8, 0, 0, 1, 14, 12, 'hB50));   // 2.0 RNE
    drain();
    send(3, 0, 0, 0, 0, 0, 1, 'h400, 1, mk(3, 0, 0, 'h5A8, 0, 0, 1, 14, 12, 'hB50));   // 2.0 trunc
    drain();
    send(4, 1, 0, 0, 0, 0, 1, 'h480, 3, mk(4, 0, 1, 'h600, 0, 0, 0, 14, 12, 'hC00));   // 9.0
    drain();
    send(5, 1, 0, 0, 0, 0, 1, 'h600, 1, mk(5, 0, 0, 'h6EE, 0, 0, 1, 14, 12, 'hDDB));   // 3.0 RNE
    drain();
    send(6, 0, 0, 0, 0, 0, 1, 'h600, 1, mk(6, 0, 0, 'h6ED, 0, 0, 1, 14, 12, 'hDDB));   // 3.0 trunc
    drain();
    send(7, 1, 0, 0, 0, 0, 1, 'h400, -1, mk(7, 0, -1, 'h5A8, 0, 0, 1, 14, 12, 'hB50)); // 0.5
    drain();
    send(8, 1, 0, 0, 1, 0, 0, 'h400, 63, mk(8, 0, 63, 'h400, 1, 0, 0, 1, 0, 0));       // +inf
    drain();
    send(9, 1, 1, 1, 0, 0, 0, 'h555, -3, mk(9, 1, -3, 'h555, 1, 0, 0, 1, 0, 0));       // NaN
    drain();
    send(10, 1, 1, 0, 0, 0, 0, 'h000, 7, mk(10, 1, -15, 0, 1, 0, 0, 1, 0, 0));         // -0
    drain();
    send(11, 1, 1, 0, 0, 1, 0, 'h400, 63, mk(11, 1, 63, 'h400, 1, 0, 0, 1, 0, 0));     // -inf
    drain();
    send(12, 1, 1, 0, 0, 0, 1, 'h400, 2, mk(12, 0, 0, 0, 1, 1, 0, 1, 0, 0));           // -4.0
    drain();

    // Backpressure: result held, busy block ignores a new operand
    bus.out_ready = 1'b0;
    send(13, 1, 0, 0, 0, 0, 1, 'h400, 2, mk(13, 0, 1, 'h400, 0, 0, 0, 14, 12, 'h800));
    for (int i = 0; i < 30 && !bus.out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid", int'(bus.out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 0, 1, 'h480, 3);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp_in_ready_%0d", k), int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    check("bp_idle_in_ready", int'(bus.in_ready), 1);

    // Reset during CALC aborts the operation
    send(14, 1, 0, 0, 0, 0, 1, 'h600, 1, mk(14, 0, 0, 'h6EE, 0, 0, 1, 14, 12, 'hDDB));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_mant_out", int'(bus.mant_out), 0);
    check("midrst_exp_out", int'(bus.exp_out), 0);
    check("midrst_iter_valid", int'(bus.iter_valid), 0);
    sb.delete();
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_out", int'(bus.out_valid), 0);
    send(15, 1, 0, 0, 0, 0, 1, 'h480, 3, mk(15, 0, 1, 'h600, 0, 0, 0, 14, 12, 'hC00));
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_iter_pipe.md
Name: sqrt_iter_pipe

Overview:
- Parametrised successor of the digit-by-digit square-root iterator. Computes the mantissa root one bit per cycle, including a guard bit, and finishes with a selectable rounding step.
- Adds a valid/ready handshake on both sides, a negative-operand invalid flag and an inexact flag.
- Sits between the special-value classifier and the result packer. Output fields use the same sign/exp/mant format as the input.

Parameters:
- MANT_W, 11: mantissa width including the implicit leading 1 (mant[MANT_W-1] = 1 for numbers).
- EXP_W, 7: signed unbiased exponent width.
- ZERO_EXP, -15: exponent emitted for a zero result.
- TRACE_EN, 1: enables the per-iteration trace outputs. When 0, iter_valid is tied to 0 and iter_root to 0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- rnd_mode  in  1  0 = truncate, 1 = round-nearest-even; sampled at accept.
- sign_in  in  1  operand sign.
- is_nan_in, is_pinf_in, is_ninf_in  in  1 each  special-value flags.
- is_num  in  1  finite nonzero operand.
- mant_in  in  MANT_W  mantissa with the implicit 1.
- exp_in  in  EXP_W (signed)  unbiased exponent.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts the result.
- sign_out  out  1  result sign.
- exp_out  out  EXP_W (signed)  result exponent.
- mant_out  out  MANT_W  result mantissa.
- special_out  out  1  result is a pass-through, zero or invalid (not computed).
- invalid  out  1  operand was negative nonzero; result is NaN.
- inexact  out  1  rounding discarded nonzero bits.
- iter_valid  out  1  pulses once per iteration.
- iter_root  out  MANT_W+1  partial root after that iteration.

Behaviour:
- Reset: all outputs 0, in_ready = 0 during reset, FSM in IDLE. A reset mid-operation aborts the computation with no output.
- FSM states: IDLE, CALC, ROUND, HOLD. in_ready = 1 only in IDLE.
- Accept rule: an operand is accepted on an edge where in_valid & in_ready. All input fields are captured at that edge.
- Special operand, IDLE to HOLD next cycle:
  - NaN or ±inf: sign, exp and mant pass through unchanged; special_out = 1.
  - !is_num (zero): sign passes through, exp_out = ZERO_EXP, mant_out = 0, special_out = 1.
  - is_num & sign_in (negative nonzero): invalid = 1, special_out = 1, sign_out = 0, exp_out = 0, mant_out = 0; the packer encodes it as NaN.
- Normal operand, IDLE to CALC:
  - Let M' = mant_in if exp_in is even, else {mant_in, 0} (2·mant_in).
  - Radicand R = M' << (MANT_W+1), width 2·MANT_W+2.
  - exp_out = exp_in >>> 1 for even exp_in, (exp_in−1) >>> 1 for odd exp_in.
  - sign_out = 0. Remainder and root are cleared; the iteration counter is loaded with MANT_W+1.
- CALC, one step per cycle:
  - rem = {rem, R[top 2 bits]}; trial = {root, 2'b01}.
  - If rem ≥ trial: rem −= trial and a 1 is shifted into root; otherwise a 0 is shifted in.
  - R shifts left by 2; the counter decrements.
  - Remainder width is MANT_W+3 bits, so no overflow is possible.
  - iter_valid pulses with iter_root = the updated root.
  - After MANT_W+1 steps the FSM goes to ROUND.
- ROUND, one cycle:
  - q = root[MANT_W:1], guard g = root[0], sticky s = (rem ≠ 0).
  - Truncate mode: mant_out = q.
  - RNE mode: mant_out = q + (g & (s | q[0])).
  - inexact = g | s.
  - A carry out of q cannot occur because the root is always below 2^MANT_W − 0.5. This is a checked assertion, not handled logic.
  - Go to HOLD.
- HOLD: out_valid = 1 and all result outputs stable until out_valid & out_ready. Then go to IDLE, drop out_valid and raise in_ready on the following cycle.
- Latency:
  - Special operands: out_valid rises 1 cycle after accept.
  - Normal operands: out_valid rises MANT_W+3 cycles after accept (14 for MANT_W = 11).
- Throughput: one operation in flight; no overlap.
- Input changes while busy are ignored.

Decomposition:
- Shared package sqrt_pkg: FSM state enum, the RNE/truncate mode constants, and the width helpers REM_W = MANT_W+3 and RAD_W = 2·MANT_W+2.
- One natural sub-module: sqrt_step. It is combinational and takes rem, root and the top radicand bits, returning the next rem and next root bit. The FSM instantiates it once.

Test Plan (MANT_W = 11):
- 4.0: mant 0x400, exp 2, RNE → mant 0x400, exp 1, inexact 0, out_valid at accept+14, 12 iter_valid pulses.
- 2.0: mant 0x400, exp 1, RNE → mant 0x5A8, exp 0, inexact 1. The same operand with truncate gives 0x5A8.
- 9.0: mant 0x480, exp 3 → mant 0x600, exp 1, inexact 0.
- Specials: +inf passes through at accept+1 with special_out = 1. Zero gives exp −15 and mant 0. −4.0 gives invalid = 1, special_out = 1.
- Backpressure: hold out_ready = 0 for 5 cycles → outputs stable, in_ready stays 0, a new in_valid is ignored until the handshake completes.
- Reset asserted mid-CALC (cycle 5) → outputs 0 next cycle and no out_valid. After reset release the next operand completes normally.
